video_axis_bridge: RTL and testbench

VIDEO_AXIS_BRIDGE -- requirements
Module: video_axis_bridge

---
 rtl/video_axis_bridge.sv | 143 ++++++++++++++
 tb/tb_video_axis_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_axis_bridge.sv
// Bridges a vsync/href/RGB pixel stream to AXI4-Stream video through a first-word-fall-through FIFO.
// Define VIDEO_AXIS_BRIDGE_STATS_EN to build the completed-frame counter on frame_cnt.
module video_axis_bridge #(
    parameter int unsigned C_IMG_WIDTH  = 1024,
    parameter int unsigned C_IMG_HEIGHT = 768,
    parameter int unsigned C_FIFO_DEPTH = 16
) (
    input  logic        clk_in2,
    input  logic        rst,
    input  logic        post_img_vsync,
    input  logic        post_img_href,
    input  logic [7:0]  post_img_red,
    input  logic [7:0]  post_img_green,
    input  logic [7:0]  post_img_blue,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic        line_err,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int unsigned AW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e      state_q;
    logic        vsync_q, href_q, sof_arm_q;
    logic [10:0] col_q, row_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [25:0] mem_q [C_FIFO_DEPTH];
    logic [25:0] head;
    logic        vs_rise, vs_fall, eol, empty, full, pop, push_req, push, flush_done;

    assign vs_rise    = post_img_vsync & ~vsync_q;
    assign vs_fall    = ~post_img_vsync & vsync_q;
    assign eol        = (col_q == 11'(C_IMG_WIDTH - 1));
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = ~empty & m_axis_tready;
    assign push_req   = (state_q == StActive) & post_img_href;
    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign push       = push_req & (~full | pop);
    assign flush_done = (state_q == StFlush) & empty;

    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? 24'd0 : head[25:2];
    assign m_axis_tuser  = ~empty & head[1];
    assign m_axis_tlast  = ~empty & head[0];

    always_ff @(posedge clk_in2) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {post_img_red, post_img_green, post_img_blue, sof_arm_q, eol};
        end
    end

    always_ff @(posedge clk_in2) begin
        if (rst) begin
            state_q    <= StIdle;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            sof_arm_q  <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow   <= 1'b0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vsync_q    <= post_img_vsync;
            href_q     <= post_img_href;
            frame_done <= flush_done;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                sof_arm_q <= 1'b0;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_req) begin
                if (!push) begin
                    overflow <= 1'b1;
                end
                if (row_q >= 11'(C_IMG_HEIGHT)) begin
                    line_err <= 1'b1;
                end
                if (eol) begin
                    col_q <= '0;
                    row_q <= row_q + 11'd1;
                end else begin
                    col_q <= col_q + 11'd1;
                end
            end
            // Line ended before reaching the configured width.
            if ((state_q == StActive) && href_q && !post_img_href && (col_q != '0)) begin
                line_err <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (vs_rise) begin
                        state_q   <= StActive;
                        col_q     <= '0;
                        row_q     <= '0;
                        sof_arm_q <= 1'b1;
                    end
                end
                StActive: begin
                    if (vs_fall) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (empty) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef VIDEO_AXIS_BRIDGE_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_in2) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (flush_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_video_axis_bridge.sv
// Self-checking bench for video_axis_bridge (W=4, H=2, depth 4): queue-based reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_video_axis_bridge;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0, href = 1'b0, tready = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast, overflow, line_err, frame_done;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int rdy_mode = 0;  // 0: tready low, 1: tready high, 2: toggle every cycle
    int dut_done = 0;
    logic [25:0] beats[$];

    video_axis_bridge #(
        .C_IMG_WIDTH (W),
        .C_IMG_HEIGHT(H),
        .C_FIFO_DEPTH(D)
    ) dut (
        .clk_in2       (clk),
        .rst           (rst),
        .post_img_vsync(vsync),
        .post_img_href (href),
        .post_img_red  (red),
        .post_img_green(green),
        .post_img_blue (blue),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .overflow      (overflow),
        .line_err      (line_err),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of beats fed by frame/line bookkeeping.
    logic [25:0] mq[$];
    bit          m_act, m_drain, m_vs, m_href, m_arm, m_ovf, m_lerr, m_done, started;
    int          m_col, m_row;
    logic [15:0] m_cnt;

    always @(posedge clk) begin : model
        int sz;
        bit mpop;
        if (rst) begin
            mq.delete();
            {m_act, m_drain, m_vs, m_href, m_arm, m_ovf, m_lerr, m_done} = '0;
            m_col = 0;
            m_row = 0;
            m_cnt = 0;
            started = 1;
        end else begin
            sz = mq.size();
            mpop = (sz != 0) && tready;
            m_done = 0;
            if (m_act && href) begin
                if (m_row >= H) m_lerr = 1;
                if (sz < D || mpop) begin
                    mq.push_back({red, green, blue, m_arm, (m_col == W - 1)});
                    m_arm = 0;
                end else begin
                    m_ovf = 1;
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (m_act && m_href && !href && m_col != 0) m_lerr = 1;
            if (!m_act && !m_drain) begin
                if (vsync && !m_vs) begin
                    m_act = 1;
                    m_col = 0;
                    m_row = 0;
                    m_arm = 1;
                end
            end else if (m_act) begin
                if (!vsync && m_vs) begin
                    m_act = 0;
                    m_drain = 1;
                end
            end else if (sz == 0) begin
                m_drain = 0;
                m_done = 1;
`ifdef VIDEO_AXIS_BRIDGE_STATS_EN
                m_cnt = m_cnt + 16'd1;
`endif
            end
            m_vs = vsync;
            m_href = href;
        end
    end

    // Per-cycle comparison, beat logging and stall-stability checks.
    logic        stall_prev = 0;
    logic [25:0] stall_data;
    always @(negedge clk) begin
        if (started) begin
            chk("tvalid", {31'd0, tvalid}, {31'd0, mq.size() != 0});
            chk("tdata", {8'd0, tdata}, mq.size() != 0 ? {8'd0, mq[0][25:2]} : 32'd0);
            chk("tuser", {31'd0, tuser}, mq.size() != 0 ? {31'd0, mq[0][1]} : 32'd0);
            chk("tlast", {31'd0, tlast}, mq.size() != 0 ? {31'd0, mq[0][0]} : 32'd0);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("line_err", {31'd0, line_err}, {31'd0, m_lerr});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
            if (stall_prev) begin
                chk("stall_stable", {6'd0, tvalid, tdata, tuser, tlast},
                    {6'd0, 1'b1, stall_data});
            end
            stall_prev = tvalid && !tready && !rst;
            stall_data = {tdata, tuser, tlast};
            if (tvalid && tready && !rst) beats.push_back({tdata, tuser, tlast});
            if (frame_done) dut_done++;
        end
    end

    task automatic drive(input bit vs, input bit hr, input int px);
        vsync = vs;
        href = hr;
        {red, green, blue} = px[23:0];
        if (rdy_mode == 2) tready = ~tready;
        else tready = (rdy_mode == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        idle(2);
        rst = 0;
        idle(1);
        beats.delete();
        dut_done = 0;
    endtask

    task automatic send_frame(input int lines, input int len, input int base);
        int p = base;
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < len; c++) drive(1, 1, p++);
            drive(1, 0, 0);
            drive(1, 0, 0);
        end
        drive(0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_tvalid", {31'd0, tvalid}, 32'd0);
        chk("reset_tdata", {8'd0, tdata}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // Nominal frame, tready high.
        rdy_mode = 1;
        send_frame(2, 4, 1);
        idle(8);
        chk("t1_beats", beats.size(), 8);
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            chk("t1_data", {8'd0, beats[i][25:2]}, i + 1);
            chk("t1_tuser", {31'd0, beats[i][1]}, (i == 0) ? 32'd1 : 32'd0);
            chk("t1_tlast", {31'd0, beats[i][0]}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("t1_done_pulses", dut_done, 1);
`ifdef VIDEO_AXIS_BRIDGE_STATS_EN
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`else
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif

        // Stalled sink: only the first four pixels survive.
        do_reset();
        rdy_mode = 0;
        send_frame(2, 4, 'h10);
        idle(3);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_tvalid", {31'd0, tvalid}, 32'd1);
        rdy_mode = 1;
        idle(10);
        chk("t2_beats", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            chk("t2_data", {8'd0, beats[i][25:2]}, 'h10 + i);
            chk("t2_tuser", {31'd0, beats[i][1]}, (i == 0) ? 32'd1 : 32'd0);
            chk("t2_tlast", {31'd0, beats[i][0]}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t2_done_pulses", dut_done, 1);

        // Toggling tready: order preserved.
        do_reset();
        rdy_mode = 2;
        send_frame(2, 4, 'h20);
        idle(12);
        chk("t3_first", {8'd0, beats.size() != 0 ? beats[0][25:2] : 24'd0}, 'h20);
        for (int i = 1; i < beats.size(); i++) begin
            chk("t3_order", {31'd0, beats[i][25:2] > beats[i-1][25:2]}, 32'd1);
        end

        // Short line.
        do_reset();
        rdy_mode = 1;
        send_frame(1, 3, 'h30);
        idle(6);
        chk("t4_line_err", {31'd0, line_err}, 32'd1);
        chk("t4_beats", beats.size(), 3);

        // href without vsync.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 'h40 + i);
            drive(0, 0, 0);
        end
        idle(3);
        chk("t5_beats", beats.size(), 0);
        chk("t5_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_line_err", {31'd0, line_err}, 32'd0);

        // Reset mid-frame with three pixels buffered.
        do_reset();
        rdy_mode = 0;
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 'h50 + i);
        chk("t6_pre_tvalid", {31'd0, tvalid}, 32'd1);
        rst = 1;
        drive(0, 0, 0);
        chk("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
        rst = 0;
        idle(2);
        beats.delete();
        rdy_mode = 1;
        send_frame(2, 4, 'h60);
        idle(8);
        chk("t6_beats", beats.size(), 8);
        chk("t6_first", {6'd0, beats.size() != 0 ? beats[0] : 26'd0}, {6'd0, 24'h60, 2'b10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
